// File: rtl/mips_seq_alu.sv
// mips_seq_alu: multi-cycle execute-stage ALU.
//   Single-cycle logic/arithmetic ops complete one cycle after accept.
//   MULU (shift-add) and DIVU (restoring shift-subtract) iterate one bit per
//   cycle and complete WIDTH+1 cycles after accept with a double-width result.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   in_valid / in_ready   operand handshake (op, a, b captured on accept)
//   out_valid / out_ready result handshake
//   result_lo, result_hi  primary result/product low/quotient, product high/remainder
//   zero_flag             result_lo == 0
//   op_err                last accepted op code was unsupported
module mips_seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero_flag,
    output logic             op_err
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MULU = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic [WIDTH-1:0]   opnd;      // multiplicand (MULU) or divisor (DIVU)
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   sc_lo;
    logic               sc_ok, is_long;
    logic [WIDTH:0]     mul_sum, div_tmp, div_diff;
    logic               div_ge;
    logic               accept;

    // Handshake outputs are pure state decodes.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign zero_flag = (result_lo == '0);

    // Single-cycle result and op classification from the live inputs.
    always_comb begin
        sc_lo   = '0;
        sc_ok   = 1'b1;
        is_long = 1'b0;
        case (op)
            OP_AND:  sc_lo = a & b;
            OP_OR:   sc_lo = a | b;
            OP_ADD:  sc_lo = a + b;
            OP_XOR:  sc_lo = a ^ b;
            OP_SUB:  sc_lo = a - b;
            OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  sc_lo = ~(a | b);
            OP_MULU, OP_DIVU: is_long = 1'b1;
            default: sc_ok = 1'b0;
        endcase
    end

    // One iteration step.
    // MULU: {acc_hi,acc_lo} starts as {0,b}; add multiplicand into hi when the
    //       lsb of lo is set, then shift the whole (WIDTH*2+1)-bit value right.
    // DIVU: {acc_hi,acc_lo} starts as {0,a}; shift left into the partial
    //       remainder, subtract the divisor if it fits, shift quotient bit in.
    //       A zero divisor always "fits", giving all-ones quotient, remainder a.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
        div_tmp  = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_tmp - {1'b0, opnd};
        div_ge   = (div_tmp >= {1'b0, opnd});
        if (is_div) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = is_long ? S_BUSY : S_DONE;
            S_BUSY: if (cnt == CNT_W'(1)) state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            is_div    <= 1'b0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            result_lo <= '0;
            result_hi <= '0;
            op_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    if (is_long) begin
                        is_div <= (op == OP_DIVU);
                        opnd   <= (op == OP_DIVU) ? b : a;
                        acc_hi <= '0;
                        acc_lo <= (op == OP_DIVU) ? a : b;
                        cnt    <= CNT_W'(WIDTH);
                        op_err <= 1'b0;
                    end else begin
                        result_lo <= sc_lo;
                        result_hi <= '0;
                        op_err    <= ~sc_ok;
                    end
                end
                S_BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - CNT_W'(1);
                    // Final step publishes straight to the outputs so DONE
                    // is reached WIDTH+1 cycles after accept.
                    if (cnt == CNT_W'(1)) begin
                        result_hi <= step_hi;
                        result_lo <= step_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mips_seq_alu.md
Name: mips_seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Executes single-cycle logic/arithmetic ops and iterative unsigned multiply and divide, producing a double-width result (hi/lo).
- Operand and result transfers use valid/ready handshakes, so the pipeline can stall on long ops.
- Sits in the execute stage beside the hi/lo register file.

Parameters:
WIDTH, 32, operand/result word width (>=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept an op
op  input  4  operation select
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result_lo  output  WIDTH  primary result / product low / quotient
result_hi  output  WIDTH  product high / remainder; 0 for single-cycle ops
zero_flag  output  1  result_lo == 0
op_err  output  1  unsupported op code was issued

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, result_lo=0, result_hi=0, op_err=0. zero_flag follows result_lo, so it reads 1 in reset.
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD (mod 2^WIDTH); 0011 XOR; 0100 SUB (a-b, mod 2^WIDTH)
  - 0101 MULU; 0110 SLTU; 0111 SLT (signed, two's complement); 1000 NOR; 1010 DIVU
  - All other codes are unsupported.
- States:
  - IDLE: in_ready=1. Accept when in_valid&&in_ready.
    - Single-cycle op -> DONE; result registered on the accept edge.
    - MULU/DIVU -> BUSY; counter loaded with WIDTH.
    - Unsupported op -> DONE with result_lo=result_hi=0, op_err=1.
  - BUSY: in_ready=0. One shift-add (MULU) or restoring shift-subtract (DIVU) step per cycle; counter decrements. Counter reaches 0 -> DONE.
  - DONE: out_valid=1, in_ready=0. Outputs held stable until out_valid&&out_ready, then -> IDLE; out_valid drops the next cycle.
- op_err: cleared on every accept of a supported op; otherwise holds its value.
- Latency, accept edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - MULU/DIVU: WIDTH+1 cycles.
- Throughput: no overlap. A new op is not accepted in the cycle a result is consumed; next accept is the following cycle.
- MULU: {result_hi,result_lo} = a*b, full 2*WIDTH unsigned product.
- DIVU: result_lo = a/b, result_hi = a%b, unsigned.
- Divide by zero: result_lo = all ones, result_hi = a. No error flag; takes the full WIDTH+1 latency.
- SLT/SLTU: result_lo = {WIDTH-1 zeros, cmp bit}; result_hi = 0.
- Operand capture: a, b, op are registered at accept. Changes on the inputs afterwards have no effect.
- in_valid while busy: ignored (in_ready=0). Source must hold in_valid until the handshake.
- out_ready while out_valid=0: ignored.
- Reset mid-operation (BUSY or DONE): abort immediately. The partial result is discarded and the reset values are restored.
- No combinational path from in_valid/out_ready to in_ready/out_valid; both are pure state decodes.

Test Plan:
- Reset asserted mid-MULU, checked in BUSY cycle 10 -> outputs return to reset values asynchronously. After release, a fresh ADD a=5, b=7 returns 12 with 1-cycle latency.
- WIDTH=32, ADD a=0xFFFFFFFF, b=1 -> result_lo=0, zero_flag=1, result_hi=0, out_valid 1 cycle after accept. Then SUB a=3, b=5 -> 0xFFFFFFFE. Then SLT a=0xFFFFFFFF, b=1 -> 1. Then SLTU with the same operands -> 0.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001. out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIVU a=100, b=7 -> result_lo=14, result_hi=2. DIVU a=0x1234, b=0 -> result_lo=0xFFFFFFFF, result_hi=0x1234, same 33-cycle latency.
- Back-pressure: ADD result with out_ready=0 for 5 cycles -> out_valid and result held stable, a second in_valid is ignored. out_ready=1 -> handshake; in_ready=1 the next cycle, then the second op is accepted.
- Unsupported op 1111 -> op_err=1, result_lo=0, zero_flag=1. A subsequent OR a=0xF0, b=0x0F -> 0xFF with op_err=0.
